stream_demux: RTL and testbench



---
 rtl/stream_demux_pkg.sv | 33 +++
 rtl/stream_demux_buf2.sv | 75 +++++++
 rtl/stream_demux.sv | 82 ++++++++
 tb/tb_stream_demux.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared defaults, occupancy encoding and helpers for the stream_demux slice.
package stream_demux_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_NOUT   = 4;
  localparam int DEF_DEST_W = 3;

  localparam int                DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } buf_cnt_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // The destination field occupies the most significant bits of a beat.
  function automatic int dest_lsb(input int dw, input int dest_w);
    return dw - dest_w;
  endfunction

endpackage

// File: rtl/stream_demux_buf2.sv
// Two-entry elastic buffer: registered input ack and a registered head, so
// there is no combinational path between the push and pop sides.
module stream_demux_buf2
  import stream_demux_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] push_dat,
  input  logic          push_req,
  output logic          push_ack,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          head_vld
);

  buf_cnt_e      cnt_r;
  buf_cnt_e      cnt_nxt_s;
  logic          wp_r;
  logic          rp_r;
  logic          ack_r;
  logic [DW-1:0] slot_r [2];
  logic          push_s;
  logic          pop_s;

  assign push_s = push_req && ack_r;
  assign pop_s  = pop && (cnt_r != CNT_EMPTY);

  // Occupancy next-state from push/pop.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case (cnt_r)
      CNT_EMPTY: begin
        if (push_s) cnt_nxt_s = CNT_ONE;
        else        cnt_nxt_s = CNT_EMPTY;
      end
      CNT_ONE: begin
        if (push_s && !pop_s)      cnt_nxt_s = CNT_FULL;
        else if (!push_s && pop_s) cnt_nxt_s = CNT_EMPTY;
        else                       cnt_nxt_s = CNT_ONE;
      end
      CNT_FULL: begin
        if (pop_s) cnt_nxt_s = CNT_ONE;
        else       cnt_nxt_s = CNT_FULL;
      end
      default: cnt_nxt_s = CNT_EMPTY;
    endcase
  end

  // Count, pointers and ack; ack is decoded from the next count so it is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= CNT_EMPTY;
      wp_r  <= 1'b0;
      rp_r  <= 1'b0;
      ack_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      ack_r <= (cnt_nxt_s != CNT_FULL);
      if (push_s) wp_r <= ~wp_r;
      if (pop_s)  rp_r <= ~rp_r;
    end
  end

  // Beat storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) slot_r[wp_r] <= push_dat;
  end

  assign push_ack = ack_r;
  assign head_dat = slot_r[rp_r];
  assign head_vld = (cnt_r != CNT_EMPTY);

endmodule

// File: rtl/stream_demux.sv
// 1-to-NOUT req/ack stream router: steers each beat to the port named by its
// top DEST_W bits, in order, dropping beats whose destination does not exist.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NOUT   = DEF_NOUT,
  parameter int DEST_W = DEF_DEST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DW-1:0]      t_0_dat,
  input  logic               t_0_req,
  output logic               t_0_ack,
  output logic [NOUT*DW-1:0] i_dat,
  output logic [NOUT-1:0]    i_req,
  input  logic [NOUT-1:0]    i_ack,
  output logic [15:0]        drop_cnt
);

  localparam int DEST_LSB = dest_lsb(DW, DEST_W);

  logic [DW-1:0]     head_dat_s;
  logic              head_vld_s;
  logic [DEST_W-1:0] hd_s;
  logic              dest_ok_s;
  logic              drop_s;
  logic              pop_s;
  logic [NOUT-1:0]   req_s;
  logic [DROP_W-1:0] drop_cnt_r;

  stream_demux_buf2 #(
    .DW(DW)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_dat (t_0_dat),
    .push_req (t_0_req),
    .push_ack (t_0_ack),
    .pop      (pop_s),
    .head_dat (head_dat_s),
    .head_vld (head_vld_s)
  );

  assign hd_s      = head_dat_s[DEST_LSB +: DEST_W];
  assign dest_ok_s = (int'(hd_s) < NOUT);

  // One-hot request towards the head's destination; acks on other ports are ignored.
  always_comb begin
    req_s = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (head_vld_s && (int'(hd_s) == k)) req_s[k] = 1'b1;
      else                                 req_s[k] = 1'b0;
    end
  end

  assign drop_s = head_vld_s && !dest_ok_s;
  assign pop_s  = drop_s || (|(req_s & i_ack));

  // Every lane carries the head beat; consumers qualify it with their own i_req bit.
  always_comb begin
    i_dat = '0;
    for (int k = 0; k < NOUT; k++) begin
      i_dat[k*DW +: DW] = head_dat_s;
    end
  end

  // Saturating count of beats discarded for an out-of-range destination.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign i_req    = req_s;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (NOUT=4 main instance, NOUT=5 drop instance).
module tb_stream_demux;

  logic         clk;
  logic         reset_n;

  logic [31:0]  t_dat;
  logic         t_req;
  logic         t_ack;
  logic [127:0] i_dat;
  logic [3:0]   i_req;
  logic [3:0]   i_ack;
  logic [15:0]  drop_cnt;

  logic [31:0]  t_dat5;
  logic         t_req5;
  logic         t_ack5;
  logic [159:0] i_dat5;
  logic [4:0]   i_req5;
  logic [4:0]   i_ack5;
  logic [15:0]  drop_cnt5;

  int n_cmp;
  int n_err;

  stream_demux #(.DW(32), .NOUT(4), .DEST_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .t_0_dat(t_dat), .t_0_req(t_req), .t_0_ack(t_ack),
    .i_dat(i_dat), .i_req(i_req), .i_ack(i_ack), .drop_cnt(drop_cnt)
  );

  stream_demux #(.DW(32), .NOUT(5), .DEST_W(3)) dut5 (
    .clk(clk), .reset_n(reset_n),
    .t_0_dat(t_dat5), .t_0_req(t_req5), .t_0_ack(t_ack5),
    .i_dat(i_dat5), .i_req(i_req5), .i_ack(i_ack5), .drop_cnt(drop_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    t_req   = 1'b1;
    t_dat   = 32'h2000_0001;
    i_ack   = 4'h0;
    t_req5  = 1'b0;
    t_dat5  = 32'h0;
    i_ack5  = 5'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (t_ack !== 1'b0) begin n_err++; $display("FAIL reset_t_ack: got %b want 0", t_ack); end
    n_cmp++; if (i_req !== 4'h0) begin n_err++; $display("FAIL reset_i_req: got %b want 0000", i_req); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
    n_cmp++; if (drop_cnt5 !== 16'h0) begin n_err++; $display("FAIL reset_drop_cnt5: got %h want 0000", drop_cnt5); end
    reset_n = 1'b1;
    t_req   = 1'b0;
    n_cmp++; if (t_ack !== 1'b0) begin n_err++; $display("FAIL release_t_ack_before_edge: got %b want 0", t_ack); end
    @(negedge clk);
    n_cmp++; if (t_ack !== 1'b1) begin n_err++; $display("FAIL release_t_ack: got %b want 1", t_ack); end
    n_cmp++; if (t_ack5 !== 1'b1) begin n_err++; $display("FAIL release_t_ack5: got %b want 1", t_ack5); end
    n_cmp++; if (i_req !== 4'h0) begin n_err++; $display("FAIL release_i_req: got %b want 0000", i_req); end
  endtask

  task automatic test_single_route();
    t_dat = 32'h2000_00AA;
    t_req = 1'b1;
    i_ack = 4'b0010;
    @(negedge clk);
    t_req = 1'b0;
    n_cmp++; if (i_req !== 4'b0010) begin n_err++; $display("FAIL single_i_req: got %b want 0010", i_req); end
    n_cmp++; if (i_dat[63:32] !== 32'h2000_00AA) begin n_err++; $display("FAIL single_lane1: got %h want 200000aa", i_dat[63:32]); end
    @(negedge clk);
    n_cmp++; if (i_req !== 4'b0000) begin n_err++; $display("FAIL single_popped: got %b want 0000", i_req); end
    i_ack = 4'h0;
  endtask

  task automatic test_streaming();
    logic [31:0] beats [8];
    logic [3:0]  reqs  [8];
    int          lane  [8];
    beats = '{32'h0000_0011, 32'h2000_0022, 32'h4000_0033, 32'h6000_0044,
              32'h0000_0055, 32'h2000_0066, 32'h4000_0077, 32'h6000_0088};
    reqs  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    lane  = '{0, 1, 2, 3, 0, 1, 2, 3};
    i_ack = 4'hF;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        n_cmp++; if (i_req !== reqs[i-1]) begin n_err++; $display("FAIL stream_i_req[%0d]: got %b want %b", i-1, i_req, reqs[i-1]); end
        n_cmp++; if (i_dat[lane[i-1]*32 +: 32] !== beats[i-1]) begin n_err++; $display("FAIL stream_dat[%0d]: got %h want %h", i-1, i_dat[lane[i-1]*32 +: 32], beats[i-1]); end
      end
      if (i < 8) begin
        n_cmp++; if (t_ack !== 1'b1) begin n_err++; $display("FAIL stream_t_ack[%0d]: got %b want 1", i, t_ack); end
        t_dat = beats[i];
        t_req = 1'b1;
      end else begin
        t_req = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++; if (i_req !== 4'h0) begin n_err++; $display("FAIL stream_drained: got %b want 0000", i_req); end
    i_ack = 4'h0;
  endtask

  task automatic test_backpressure();
    i_ack = 4'h0;
    t_dat = 32'h4000_0A01;
    t_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (t_ack !== 1'b1) begin n_err++; $display("FAIL bp_ack_after1: got %b want 1", t_ack); end
    t_dat = 32'h4000_0A02;
    @(negedge clk);
    n_cmp++; if (t_ack !== 1'b0) begin n_err++; $display("FAIL bp_ack_full: got %b want 0", t_ack); end
    t_dat = 32'h4000_0A03;
    @(negedge clk);
    n_cmp++; if (t_ack !== 1'b0) begin n_err++; $display("FAIL bp_ack_still_full: got %b want 0", t_ack); end
    n_cmp++; if (i_req !== 4'b0100) begin n_err++; $display("FAIL bp_i_req: got %b want 0100", i_req); end
    n_cmp++; if (i_dat[95:64] !== 32'h4000_0A01) begin n_err++; $display("FAIL bp_head_a: got %h want 40000a01", i_dat[95:64]); end
    i_ack = 4'b0100;
    @(negedge clk);
    i_ack = 4'h0;
    n_cmp++; if (t_ack !== 1'b1) begin n_err++; $display("FAIL bp_ack_after_pop: got %b want 1", t_ack); end
    n_cmp++; if (i_dat[95:64] !== 32'h4000_0A02) begin n_err++; $display("FAIL bp_head_b: got %h want 40000a02", i_dat[95:64]); end
    @(negedge clk);
    t_req = 1'b0;
    n_cmp++; if (t_ack !== 1'b0) begin n_err++; $display("FAIL bp_third_accepted: got %b want 0", t_ack); end
    n_cmp++; if (i_dat[95:64] !== 32'h4000_0A02) begin n_err++; $display("FAIL bp_head_b_held: got %h want 40000a02", i_dat[95:64]); end
    i_ack = 4'b0100;
    @(negedge clk);
    n_cmp++; if (i_dat[95:64] !== 32'h4000_0A03) begin n_err++; $display("FAIL bp_head_c: got %h want 40000a03", i_dat[95:64]); end
    n_cmp++; if (i_req !== 4'b0100) begin n_err++; $display("FAIL bp_i_req_c: got %b want 0100", i_req); end
    @(negedge clk);
    n_cmp++; if (i_req !== 4'h0) begin n_err++; $display("FAIL bp_drained: got %b want 0000", i_req); end
    i_ack = 4'h0;
  endtask

  task automatic test_hol_stray_ack();
    i_ack = 4'h0;
    t_dat = 32'h6000_0D03;
    t_req = 1'b1;
    @(negedge clk);
    t_dat = 32'h0000_0E00;
    @(negedge clk);
    t_req = 1'b0;
    i_ack = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (i_req !== 4'b1000) begin n_err++; $display("FAIL hol_i_req[%0d]: got %b want 1000", i, i_req); end
      n_cmp++; if (i_dat[127:96] !== 32'h6000_0D03) begin n_err++; $display("FAIL hol_head[%0d]: got %h want 60000d03", i, i_dat[127:96]); end
    end
    i_ack = 4'b1000;
    @(negedge clk);
    n_cmp++; if (i_req !== 4'b0001) begin n_err++; $display("FAIL hol_next_i_req: got %b want 0001", i_req); end
    n_cmp++; if (i_dat[31:0] !== 32'h0000_0E00) begin n_err++; $display("FAIL hol_next_dat: got %h want 00000e00", i_dat[31:0]); end
    @(negedge clk);
    n_cmp++; if (i_req !== 4'b0001) begin n_err++; $display("FAIL hol_next_unacked: got %b want 0001", i_req); end
    i_ack = 4'b0001;
    @(negedge clk);
    n_cmp++; if (i_req !== 4'h0) begin n_err++; $display("FAIL hol_drained: got %b want 0000", i_req); end
    i_ack = 4'h0;
  endtask

  task automatic test_drop();
    logic [15:0] exp_drop;
    logic        ack_low;
    i_ack5 = 5'b11111;
    t_dat5 = 32'hE000_0001;
    t_req5 = 1'b1;
    @(negedge clk);
    t_req5 = 1'b0;
    n_cmp++; if (i_req5 !== 5'b00000) begin n_err++; $display("FAIL drop_no_req: got %b want 00000", i_req5); end
    n_cmp++; if (drop_cnt5 !== 16'd0) begin n_err++; $display("FAIL drop_cnt_before: got %h want 0000", drop_cnt5); end
    @(negedge clk);
    n_cmp++; if (drop_cnt5 !== 16'd1) begin n_err++; $display("FAIL drop_cnt_one: got %h want 0001", drop_cnt5); end
    n_cmp++; if (i_req5 !== 5'b00000) begin n_err++; $display("FAIL drop_consumed: got %b want 00000", i_req5); end
    t_dat5 = 32'h8000_0004;
    t_req5 = 1'b1;
    @(negedge clk);
    t_req5 = 1'b0;
    n_cmp++; if (i_req5 !== 5'b10000) begin n_err++; $display("FAIL drop_dest4_req: got %b want 10000", i_req5); end
    n_cmp++; if (i_dat5[159:128] !== 32'h8000_0004) begin n_err++; $display("FAIL drop_dest4_dat: got %h want 80000004", i_dat5[159:128]); end
    @(negedge clk);
    n_cmp++; if (drop_cnt5 !== 16'd1) begin n_err++; $display("FAIL drop_cnt_valid_beat: got %h want 0001", drop_cnt5); end
    exp_drop = 16'd1;
    ack_low  = 1'b0;
    while (exp_drop != 16'hFFFF) begin
      if (t_ack5 !== 1'b1) ack_low = 1'b1;
      t_dat5   = (exp_drop[0]) ? 32'hC000_0000 : 32'hA000_0000;
      t_req5   = 1'b1;
      exp_drop = exp_drop + 16'd1;
      @(negedge clk);
    end
    t_req5 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack_low !== 1'b0) begin n_err++; $display("FAIL drop_stream_t_ack: got low want always 1"); end
    n_cmp++; if (drop_cnt5 !== 16'hFFFF) begin n_err++; $display("FAIL drop_cnt_max: got %h want ffff", drop_cnt5); end
    t_dat5 = 32'hE000_0002;
    t_req5 = 1'b1;
    @(negedge clk);
    t_req5 = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (drop_cnt5 !== 16'hFFFF) begin n_err++; $display("FAIL drop_cnt_saturate: got %h want ffff", drop_cnt5); end
    n_cmp++; if (i_req5 !== 5'b00000) begin n_err++; $display("FAIL drop_final_idle: got %b want 00000", i_req5); end
    i_ack5 = 5'b00000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_route();
    test_streaming();
    test_backpressure();
    test_hol_stray_ack();
    test_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
